packet_buffer_stream_reader: RTL and testbench

PACKET_BUFFER_STREAM_READER -- requirements
Module: packet_buffer_stream_reader

---
 rtl/packet_buffer_stream_reader.sv | 212 +++++++++++++++++++++
 tb/tb_packet_buffer_stream_reader.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_buffer_stream_reader.sv
// Streams a packet out of a buffer slot as keep-qualified beats, then acks the slot.
// Define PACKET_BUFFER_READER_STATS_EN to add the packet_count_o ack counter.
module packet_buffer_stream_reader #(
  parameter int data_width_p = 64,
  parameter int els_p = 2048,
  localparam int addr_w = $clog2(els_p),
  localparam int size_w = $clog2(els_p + 1),
  localparam int keep_w = data_width_p / 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    packet_avail_i,
  input  logic [size_w-1:0]       packet_rsize_i,
  output logic                    packet_ack_o,
  output logic                    packet_rvalid_o,
  output logic [addr_w-1:0]       packet_raddr_o,
  input  logic [data_width_p-1:0] packet_rdata_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [data_width_p-1:0] m_data_o,
  output logic [keep_w-1:0]       m_keep_o,
  output logic                    m_last_o
`ifdef PACKET_BUFFER_READER_STATS_EN
  ,
  output logic [31:0]             packet_count_o
`endif
);

  localparam int kshift = $clog2(keep_w);
  localparam int bw = size_w + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [size_w-1:0] size_q;
  logic [bw-1:0]     beats_q;
  logic [bw-1:0]     beats_n;
  logic [bw-1:0]     beat_cnt;
  logic [addr_w-1:0] addr_q;

  logic              in_flight;
  logic              fl_last;
  logic [keep_w-1:0] fl_keep;

  logic [data_width_p-1:0] f_data [2];
  logic [keep_w-1:0]       f_keep [2];
  logic [1:0]              f_last;
  logic                    rd_ptr;
  logic                    wr_ptr;
  logic [1:0]              count;

  logic [2:0]        occ;
  logic              fifo_ne;
  logic              hs;
  logic              space;
  logic              issue;
  logic              last_rd;
  logic              push;
  logic              pop;
  logic              ack;
  logic [kshift-1:0] rem;
  logic [keep_w-1:0] last_keep;
  logic [keep_w-1:0] rd_keep;

  assign fifo_ne   = count != 2'd0;
  assign m_valid_o = fifo_ne | in_flight;
  assign hs        = m_valid_o & m_ready_i;

  // Credit: a read may issue only if its data is sure to find a FIFO slot.
  assign occ   = {1'b0, count} + {2'b0, in_flight};
  assign space = (occ - {2'b0, hs}) < 3'd2;
  assign issue = (state == READ) & packet_avail_i & space;

  assign last_rd = beat_cnt == (beats_q - bw'(1));
  assign rem     = size_q[kshift-1:0];
  assign beats_n = ({1'b0, packet_rsize_i} + bw'(keep_w - 1)) >> kshift;

  always_comb begin
    last_keep = '0;
    for (int i = 0; i < keep_w; i++) begin
      last_keep[i] = (rem == '0) || (kshift'(i) < rem);
    end
  end

  assign rd_keep = last_rd ? last_keep : '1;

  always_comb begin
    state_n = state;
    ack     = 1'b0;
    unique case (state)
      IDLE: begin
        if (packet_avail_i) begin
          state_n = (packet_rsize_i == '0) ? ACK : READ;
        end
      end
      READ: begin
        if (issue && last_rd) begin
          state_n = ACK;
        end
      end
      ACK: begin
        ack     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign packet_ack_o    = ack;
  assign packet_rvalid_o = issue;
  assign packet_raddr_o  = addr_q;

  // Returning data bypasses the FIFO when it is empty and the sink is ready.
  assign push = in_flight & ~(~fifo_ne & m_ready_i);
  assign pop  = fifo_ne & m_ready_i;

  always_comb begin
    m_data_o = '0;
    m_keep_o = '0;
    m_last_o = 1'b0;
    if (fifo_ne) begin
      m_data_o = f_data[rd_ptr];
      m_keep_o = f_keep[rd_ptr];
      m_last_o = f_last[rd_ptr];
    end else if (in_flight) begin
      m_data_o = packet_rdata_i;
      m_keep_o = fl_keep;
      m_last_o = fl_last;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      size_q   <= '0;
      beats_q  <= '0;
      beat_cnt <= '0;
      addr_q   <= '0;
    end else if (state == IDLE) begin
      beat_cnt <= '0;
      addr_q   <= '0;
      if (packet_avail_i) begin
        size_q  <= packet_rsize_i;
        beats_q <= beats_n;
      end
    end else if (issue) begin
      beat_cnt <= beat_cnt + bw'(1);
      addr_q   <= addr_q + addr_w'(keep_w);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      in_flight <= 1'b0;
      fl_keep   <= '0;
      fl_last   <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        fl_keep <= rd_keep;
        fl_last <= last_rd;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_keep[i] <= '0;
      end
      f_last <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        f_data[wr_ptr] <= packet_rdata_i;
        f_keep[wr_ptr] <= fl_keep;
        f_last[wr_ptr] <= fl_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef PACKET_BUFFER_READER_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      packet_count_o <= '0;
    end else if (ack) begin
      packet_count_o <= packet_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_packet_buffer_stream_reader.sv
// Bench for packet_buffer_stream_reader: vector table, corner sequences,
// random traffic against a byte-level packet model.
`timescale 1ns/1ps
module tb_packet_buffer_stream_reader;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int AW = 11;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          avail;
  logic [SW-1:0] rsize;
  logic          ack;
  logic          rvalid;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_last;

  logic          a32;
  logic [SW-1:0] rs32;
  logic          ack32;
  logic          rv32;
  logic [AW-1:0] ra32;
  logic [31:0]   rd32;
  logic          v32;
  logic [31:0]   d32;
  logic [3:0]    k32;
  logic          last32;
`ifdef PACKET_BUFFER_READER_STATS_EN
  logic [31:0]   pc64;
  logic [31:0]   pc32;
`endif

  always #5 clk = ~clk;

  packet_buffer_stream_reader #(.data_width_p(64), .els_p(2048)) dut (
    .clk_i(clk), .reset_i(rst),
    .packet_avail_i(avail), .packet_rsize_i(rsize),
    .packet_ack_o(ack), .packet_rvalid_o(rvalid),
    .packet_raddr_o(raddr), .packet_rdata_i(rdata),
    .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_keep_o(m_keep), .m_last_o(m_last)
`ifdef PACKET_BUFFER_READER_STATS_EN
    , .packet_count_o(pc64)
`endif
  );

  packet_buffer_stream_reader #(.data_width_p(32), .els_p(2048)) dut32 (
    .clk_i(clk), .reset_i(rst),
    .packet_avail_i(a32), .packet_rsize_i(rs32),
    .packet_ack_o(ack32), .packet_rvalid_o(rv32),
    .packet_raddr_o(ra32), .packet_rdata_i(rd32),
    .m_valid_o(v32), .m_ready_i(1'b1),
    .m_data_o(d32), .m_keep_o(k32), .m_last_o(last32)
`ifdef PACKET_BUFFER_READER_STATS_EN
    , .packet_count_o(pc32)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    int          size;
    int          beats;
    logic [7:0]  lkeep;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  beat_t exp_q[$];
  int    size_q[$];
  int    pid_q[$];
  int    next_pid = 1;

  int cyc = 0;
  int beats_obs, ack_cnt, rd_cnt, rd_zero, first_cyc, rise_cyc;
  logic [KW-1:0] last_keep_obs;
  bit ack_pend = 0, rd_pend = 0, rand_ready = 0, avail_prev = 0;
  int rd_addr, rd_pid;
  bit stall_prev = 0;
  beat_t held;

  int sizes32[$];
  logic [4:0] keep32_q[$];
  int ack32_cnt = 0;
  bit ack32_pend = 0;
  logic [AW-1:0] ra32_q = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] mem_byte(int pid, int a);
    return 8'(pid * 37 + a * 5 + 1);
  endfunction

  function automatic logic [DW-1:0] mem_word(int pid, int a);
    logic [DW-1:0] w;
    for (int i = 0; i < KW; i++) w[8*i +: 8] = mem_byte(pid, a + i);
    return w;
  endfunction

  function automatic void expect_pkt(int pid, int sz);
    int nb, rem;
    beat_t b;
    nb = (sz + KW - 1) / KW;
    rem = sz % KW;
    for (int k = 0; k < nb; k++) begin
      b.data = mem_word(pid, k * KW);
      b.last = (k == nb - 1);
      b.keep = (b.last && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
      exp_q.push_back(b);
    end
  endfunction

  task automatic push_pkt(int sz);
    size_q.push_back(sz);
    pid_q.push_back(next_pid);
    expect_pkt(next_pid, sz);
    next_pid++;
  endtask

  task automatic clr();
    beats_obs = 0;
    ack_cnt = 0;
    rd_cnt = 0;
    rd_zero = 0;
    first_cyc = -1;
    last_keep_obs = '0;
  endtask

  task automatic wait_idle(int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #2;
      if (size_q.size() == 0 && exp_q.size() == 0 && !m_valid) done = 1;
    end
    chk("idle_timeout", 64'(done), 64'd1);
  endtask

  // Producer and memory model for the 64-bit instance.
  always @(posedge clk) begin
    #1;
    if (ack_pend) begin
      void'(size_q.pop_front());
      void'(pid_q.pop_front());
      ack_pend = 0;
    end
    avail = size_q.size() != 0;
    rsize = avail ? SW'(size_q[0]) : '0;
    rdata = rd_pend ? mem_word(rd_pid, rd_addr) : {$urandom, $urandom};
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst) begin
      stall_prev = 0;
    end else begin
      rd_pend = 0;
      if (rvalid) begin
        chk("rd_avail_align", 64'({avail, raddr[2:0]}), 64'h8);
        rd_cnt++;
        if (raddr == '0) rd_zero++;
        rd_pend = 1;
        rd_addr = int'(raddr);
        rd_pid = (pid_q.size() != 0) ? pid_q[0] : 0;
      end
      if (ack) begin
        ack_cnt++;
        ack_pend = 1;
      end
      if (stall_prev) begin
        chk("stall_hold", 64'({m_valid, m_last, m_keep}),
            64'({1'b1, held.last, held.keep}));
        chk("stall_data", m_data, held.data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e.data);
          chk("beat_keep_last", 64'({m_keep, m_last}), 64'({e.keep, e.last}));
        end
        beats_obs++;
        last_keep_obs = m_keep;
        if (first_cyc < 0) first_cyc = cyc;
      end
      stall_prev = m_valid && !m_ready;
      held.data = m_data;
      held.keep = m_keep;
      held.last = m_last;
      if (avail && !avail_prev) rise_cyc = cyc;
      avail_prev = avail;
    end
  end

  // Producer and monitor for the 32-bit instance.
  always @(posedge clk) begin
    #1;
    if (ack32_pend) begin
      void'(sizes32.pop_front());
      ack32_pend = 0;
    end
    a32 = sizes32.size() != 0;
    rs32 = a32 ? SW'(sizes32[0]) : '0;
    rd32 = 32'(ra32_q);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (v32) keep32_q.push_back({last32, k32});
      if (ack32) begin
        ack32_cnt++;
        ack32_pend = 1;
      end
      ra32_q = ra32;
    end
  end

  vec_t vt[6];
  logic [4:0] e32[4];

  initial begin
    vt[0] = '{size: 20,   beats: 3,   lkeep: 8'h0F};
    vt[1] = '{size: 8,    beats: 1,   lkeep: 8'hFF};
    vt[2] = '{size: 1,    beats: 1,   lkeep: 8'h01};
    vt[3] = '{size: 0,    beats: 0,   lkeep: 8'h00};
    vt[4] = '{size: 63,   beats: 8,   lkeep: 8'h7F};
    vt[5] = '{size: 2048, beats: 256, lkeep: 8'hFF};
    e32[0] = 5'h0F;
    e32[1] = 5'h11;
    e32[2] = 5'h0F;
    e32[3] = 5'h1F;

    rst = 1'b1;
    m_ready = 1'b0;
    avail = 1'b0;
    rsize = '0;
    rdata = '0;
    a32 = 1'b0;
    rs32 = '0;
    rd32 = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ctl", 64'({ack, rvalid, m_valid, m_last}), 64'd0);
    chk("reset_raddr", 64'(raddr), 64'd0);
    chk("reset_data", m_data, 64'd0);
    chk("reset_keep", 64'(m_keep), 64'd0);
    chk("reset_ctl32", 64'({ack32, rv32, v32, last32, k32}), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Single packets, sink always ready.
    m_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      clr();
      push_pkt(vt[v].size);
      wait_idle(1000);
      chk($sformatf("v%0d_beats", v), 64'(beats_obs), 64'(vt[v].beats));
      chk($sformatf("v%0d_acks", v), 64'(ack_cnt), 64'd1);
      chk($sformatf("v%0d_reads", v), 64'(rd_cnt), 64'(vt[v].beats));
      if (vt[v].beats > 0) begin
        chk($sformatf("v%0d_lkeep", v), 64'(last_keep_obs), 64'(vt[v].lkeep));
        chk($sformatf("v%0d_latency", v), 64'(first_cyc - rise_cyc), 64'd2);
      end
    end

    // Sink stalled: only two reads may be outstanding.
    clr();
    m_ready = 1'b0;
    push_pkt(16);
    repeat (7) @(posedge clk);
    #2;
    chk("stall_reads", 64'(rd_cnt), 64'd2);
    chk("stall_valid", 64'(m_valid), 64'd1);
    chk("stall_ack", 64'(ack_cnt), 64'd1);
    m_ready = 1'b1;
    wait_idle(200);
    chk("stall_beats", 64'(beats_obs), 64'd2);
    chk("stall_lkeep", 64'(last_keep_obs), 64'hFF);

    // Back-to-back packets.
    clr();
    push_pkt(64);
    push_pkt(64);
    wait_idle(300);
    chk("b2b_beats", 64'(beats_obs), 64'd16);
    chk("b2b_acks", 64'(ack_cnt), 64'd2);
    chk("b2b_addr0", 64'(rd_zero), 64'd2);

    // Reset in the middle of a packet.
    clr();
    push_pkt(40);
    for (int i = 0; i < 100 && beats_obs < 2; i++) begin
      @(posedge clk);
      #3;
    end
    chk("mid_reached", 64'(beats_obs), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", 64'({ack, rvalid, m_valid, m_last}), 64'd0);
    chk("mid_rst_out", 64'({raddr, m_keep}), 64'd0);
    chk("mid_rst_data", m_data, 64'd0);
    chk("mid_no_ack", 64'(ack_cnt), 64'd0);
    exp_q.delete();
    for (int i = 0; i < size_q.size(); i++) expect_pkt(pid_q[i], size_q[i]);
    clr();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_idle(300);
    chk("mid_replay_beats", 64'(beats_obs), 64'd5);
    chk("mid_replay_ack", 64'(ack_cnt), 64'd1);
    chk("mid_replay_addr0", 64'(rd_zero), 64'd1);

    // Random sizes and random back-pressure.
    clr();
    rand_ready = 1;
    for (int p = 0; p < 25; p++) push_pkt(int'($urandom_range(0, 300)));
    wait_idle(5000);
    rand_ready = 0;
    m_ready = 1'b1;
    chk("rand_acks", 64'(ack_cnt), 64'd25);

    // 32-bit instance: sizes 5, 0, 8.
    sizes32.push_back(5);
    sizes32.push_back(0);
    sizes32.push_back(8);
    for (int i = 0; i < 200 && sizes32.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    chk("w32_nbeats", 64'(keep32_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < keep32_q.size())
        chk($sformatf("w32_beat%0d", i), 64'(keep32_q[i]), 64'(e32[i]));
    end
    chk("w32_acks", 64'(ack32_cnt), 64'd3);
`ifdef PACKET_BUFFER_READER_STATS_EN
    chk("w32_count", 64'(pc32), 64'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
